axi4_lite_cmd_master: RTL and testbench
=======================================

# axi4_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command port (read or write, one beat) into AXI4-Lite transactions and returns one response per command. It sits directly upstream of the AXI4-Lite-to-memory slave bridge, driving that bridge's AXI4-Lite slave port from test sequencers, debug bridges or simple controllers. Misaligned addresses are rejected locally, with no bus activity.

## Interface
Parameters (widths are taken from the attached `axi4_lite_if` instance):
- ALEN, `axi.ALEN`: byte address width.
- DLEN, `axi.DLEN`: data width.
- SLEN, `axi.SLEN`: strobe width; DLEN = 8*SLEN.
- Align, $clog2(SLEN): count of byte-offset address LSBs.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ALEN  byte address.
- cmd_wdata  in  DLEN  write data; ignored for reads.
- cmd_wstrb  in  SLEN  byte strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_we  out  1  echo of the command's cmd_we.
- rsp_rdata  out  DLEN  read data; 0 for writes and rejected commands.
- rsp_resp  out  2  bresp/rresp from the slave, or SLVERR (2'b10) if rejected locally.
- axi  `axi4_lite_if.M`  master modport; drives aw*, w*, ar*, bready, rready.

## Operation
States: IDLE, WRITE, READ and RESP.
- IDLE:
  - cmd_ready = 1 (combinational, state==IDLE).
  - On cmd_valid & cmd_ready, register cmd_we, cmd_addr, cmd_wdata and cmd_wstrb.
  - If cmd_addr[Align-1:0] != 0, go to RESP with rsp_resp=2'b10 and rsp_rdata=0. No AXI valid is raised.
  - Else if cmd_we, go to WRITE. Otherwise go to READ.
- WRITE:
  - awvalid and wvalid are asserted together on entry.
  - Each channel has its own done flag. A valid drops in the cycle after its own handshake and is never re-raised within the command.
  - Either order of aw/w acceptance is legal.
  - bready = 1 throughout WRITE.
  - On the b handshake, capture bresp into rsp_resp, set rsp_rdata=0 and go to RESP.
- READ:
  - arvalid is asserted on entry and drops in the cycle after the ar handshake.
  - rready = 1 throughout READ.
  - On the r handshake, capture rdata and rresp and go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
- Bus outputs:
  - awaddr, wdata and wstrb come from the registered command; araddr likewise.
  - They are stable while their valid is high.
  - Once a valid is asserted, it never drops before its handshake (AXI rule).
- A b or r beat arriving outside WRITE/READ is ignored; bready and rready are 0 outside those states.

## Timing
- Reset (rstn=0 at a clock edge):
  - State goes to IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_we = 0.
  - rsp_resp = 2'b00; rsp_rdata = 0.
  - The aw/w done flags clear.
- Commands are not accepted while rstn=0. Reset mid-transaction abandons it immediately; no response is produced.
- Latency, command accept edge = cycle 0, slave accepting and responding as soon as possible:
  - Write: aw/w valid in cycle 1, bvalid in cycle 2, rsp_valid in cycle 3.
  - Read: arvalid in cycle 1, rvalid in cycle 2, rsp_valid in cycle 3.
  - Rejected command: rsp_valid in cycle 1.
- Peak throughput is one command per 4 cycles when rsp_ready is tied high. The next cmd_ready is 1 in the cycle after the rsp handshake.
- Only one transaction is outstanding at a time; back-pressure is applied through cmd_ready=0 in all states except IDLE.
- If aw and w are accepted in different cycles, the b response is still captured whenever it arrives. bresp=SLVERR is passed through unchanged.

## Test plan
- Write cmd (addr=0x10, wdata=0xDEADBEEF, wstrb=all-ones) into the bridge+memory, then a read of 0x10. Required: rsp_resp=00 for both; the read returns rsp_rdata=0xDEADBEEF; each rsp_valid appears 3 cycles after its command accept.
- Slave holds wready=0 for 3 cycles while awready=1. Required: awvalid drops after 1 cycle; wvalid is held 4 cycles with stable wdata; exactly one rsp is produced; rsp_we=1.
- Misaligned read cmd_addr=0x3 (SLEN=4). Required: no arvalid ever; rsp_valid in cycle 1 with rsp_resp=10 and rsp_rdata=0.
- rsp_ready held low for 5 cycles after a read. Required: rsp_valid and rsp_rdata are stable all 5 cycles; cmd_ready stays 0; a new cmd is accepted the cycle after rsp_ready rises.
- rstn pulsed low while in WRITE with awvalid high. Required: all AXI valids, bready and rsp_valid are 0 the next cycle; no response is produced; the next command behaves normally.
- Slave returns bresp=10. Required: rsp_resp=10 and rsp_rdata=0.

Source files
------------

// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and its slave.
// Parameters: ALEN byte address width, DLEN data width, SLEN strobe width
// (DLEN = 8*SLEN).
// Modports: M (master drives aw*, w*, ar*, bready, rready),
//           S (slave drives the ready/response side).
interface axi4_lite_if #(
  parameter int unsigned ALEN = 32,
  parameter int unsigned DLEN = 32,
  parameter int unsigned SLEN = DLEN / 8
);
  logic            awvalid;
  logic            awready;
  logic [ALEN-1:0] awaddr;
  logic            wvalid;
  logic            wready;
  logic [DLEN-1:0] wdata;
  logic [SLEN-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [ALEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [DLEN-1:0] rdata;
  logic [1:0]      rresp;

  modport M (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport S (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: converts one-beat read/write commands
// into AXI4-Lite transactions and returns one response per command.
// Misaligned commands are answered locally with SLVERR and no bus activity.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_we/addr/wdata/wstrb      command fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_we/rsp_rdata/rsp_resp    response fields (held stable in RESP)
//   axi                          AXI4-Lite master modport
// ALEN/DLEN/SLEN must match the attached axi4_lite_if instance.
module axi4_lite_cmd_master #(
  parameter int unsigned ALEN = 32,
  parameter int unsigned DLEN = 32,
  parameter int unsigned SLEN = DLEN / 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [ALEN-1:0] cmd_addr,
  input  logic [DLEN-1:0] cmd_wdata,
  input  logic [SLEN-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_we,
  output logic [DLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_resp,
  axi4_lite_if.M          axi
);

  // Byte-offset bits below the bus word; a mask avoids a [-1:0] slice when SLEN=1.
  localparam logic [ALEN-1:0] ALIGN_MASK = ALEN'(SLEN - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t state, state_nxt;

  logic            aw_done, w_done, ar_done;
  logic [ALEN-1:0] addr_q;
  logic [DLEN-1:0] wdata_q;
  logic [SLEN-1:0] wstrb_q;

  logic cmd_hs, misaligned;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_hs     = cmd_valid & cmd_ready;
  assign misaligned = (cmd_addr & ALIGN_MASK) != '0;
  assign aw_hs      = axi.awvalid & axi.awready;
  assign w_hs       = axi.wvalid & axi.wready;
  assign b_hs       = axi.bvalid & axi.bready;
  assign ar_hs      = axi.arvalid & axi.arready;
  assign r_hs       = axi.rvalid & axi.rready;
  assign rsp_hs     = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (misaligned)  state_nxt = RESP;
          else if (cmd_we) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      WRITE:   if (b_hs)   state_nxt = RESP;
      READ:    if (r_hs)   state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Valids are pure functions of state and done flags, so reset clears them
  // immediately and each one stays up until its own handshake.
  always_comb begin
    cmd_ready   = (state == IDLE);
    rsp_valid   = (state == RESP);
    axi.awvalid = (state == WRITE) && !aw_done;
    axi.wvalid  = (state == WRITE) && !w_done;
    axi.bready  = (state == WRITE);
    axi.arvalid = (state == READ) && !ar_done;
    axi.rready  = (state == READ);
    axi.awaddr  = addr_q;
    axi.araddr  = addr_q;
    axi.wdata   = wdata_q;
    axi.wstrb   = wstrb_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_we    <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        rsp_we  <= cmd_we;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
        if (misaligned) begin
          rsp_resp  <= 2'b10;
          rsp_rdata <= '0;
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (ar_hs) ar_done <= 1'b1;
      if (b_hs) begin
        rsp_resp  <= axi.bresp;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_resp  <= axi.rresp;
        rsp_rdata <= axi.rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
module tb_axi4_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  always #5 clk = ~clk;

  axi4_lite_if #(.ALEN(32), .DLEN(32), .SLEN(4)) axi ();

  axi4_lite_cmd_master #(.ALEN(32), .DLEN(32), .SLEN(4)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi(axi)
  );

  // ---------------- slave model: zero-wait memory with wready stall ----------
  int          w_stall = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          w_wait_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] mem [16];
  logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
  logic [31:0] s_addr, s_data;
  logic [3:0]  s_strb;

  assign axi.awready = 1'b1;
  assign axi.arready = 1'b1;
  assign axi.wready  = (w_wait_cnt >= w_stall);
  assign s_aw_hs = axi.awvalid & axi.awready;
  assign s_w_hs  = axi.wvalid & axi.wready;
  assign s_b_hs  = axi.bvalid & axi.bready;
  assign s_ar_hs = axi.arvalid & axi.arready;
  assign s_r_hs  = axi.rvalid & axi.rready;
  assign s_addr  = s_aw_hs ? axi.awaddr : aw_addr_s;
  assign s_data  = s_w_hs ? axi.wdata : w_data_s;
  assign s_strb  = s_w_hs ? axi.wstrb : w_strb_s;

  always @(posedge clk) begin
    if (!rstn) begin
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_addr_s  <= '0;
      w_data_s   <= '0;
      w_strb_s   <= '0;
      w_wait_cnt <= 0;
    end else begin
      w_wait_cnt <= (axi.wvalid && !axi.wready) ? w_wait_cnt + 1 : 0;
      if (s_aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axi.awaddr; end
      if (s_w_hs)  begin w_got <= 1'b1; w_data_s <= axi.wdata; w_strb_s <= axi.wstrb; end
      if (s_b_hs) axi.bvalid <= 1'b0;
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !axi.bvalid) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= bresp_cfg;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        for (int i = 0; i < 4; i++)
          if (s_strb[i]) mem[s_addr[5:2]][8*i +: 8] <= s_data[8*i +: 8];
      end
      if (s_r_hs) axi.rvalid <= 1'b0;
      if (s_ar_hs) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= mem[axi.araddr[5:2]];
        axi.rresp  <= 2'b00;
      end
    end
  end

  // ---------------- checking infrastructure ---------------------------------
  typedef struct packed {
    logic        we;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   rsp_cnt = 0;
  int   aw_cyc = 0, w_cyc = 0, ar_cyc = 0, w_unstable = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: pops the scoreboard on every response handshake; also tracks bus activity.
  initial begin
    exp_t        e;
    logic        prev_w_pend = 1'b0;
    logic [31:0] prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          if (sb_q.size() == 0) fail_now("unexpected_rsp");
          else begin
            e = sb_q.pop_front();
            check("rsp_we", {31'b0, rsp_we}, {31'b0, e.we});
            check("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
            check("rsp_rdata", rsp_rdata, e.rdata);
          end
        end
        if (axi.awvalid) aw_cyc++;
        if (axi.wvalid)  w_cyc++;
        if (axi.arvalid) ar_cyc++;
        if (prev_w_pend && axi.wdata != prev_wdata) w_unstable++;
        prev_w_pend = axi.wvalid && !axi.wready;
        prev_wdata  = axi.wdata;
      end else prev_w_pend = 1'b0;
    end
  end

  // Issue one command; exp_lat/exp_wait < 0 skip that timing check.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [1:0] eresp, input logic [31:0] erdata,
                       input int exp_lat, input int exp_wait, input logic hold_rsp);
    int waits, lat;
    exp_t e;
    e.we = we; e.resp = eresp; e.rdata = erdata;
    sb_q.push_back(e);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      waits++;
      if (waits > 20) begin
        fail_now("cmd_accept");
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (hold_rsp) rsp_ready = 1'b0;
    if (exp_wait >= 0) check("cmd_wait", waits, exp_wait);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) fail_now("rsp_valid");
    else if (exp_lat >= 0) check("rsp_latency", lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ---------------------------------------
  initial begin
    int aw0, w0, ar0, un0, rc0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_valids", {29'b0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
    check("reset_readys", {30'b0, axi.bready, axi.rready}, 32'd0);
    check("reset_rsp_fields", {29'b0, rsp_we, rsp_resp}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);

    // Write then read back.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 3, 0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 3, 0, 1'b0);

    // wready held low 3 cycles: aw accepted in cycle 1, w in cycle 4, rsp in cycle 6.
    w_stall = 3;
    aw0 = aw_cyc; w0 = w_cyc; un0 = w_unstable; rc0 = rsp_cnt;
    issue(1'b1, 32'h14, 32'h12345678, 4'hF, 2'b00, 32'h0, 6, 0, 1'b0);
    w_stall = 0;
    @(negedge clk); #1;
    check("stall_aw_cycles", aw_cyc - aw0, 1);
    check("stall_w_cycles", w_cyc - w0, 4);
    check("stall_wdata_stable", w_unstable - un0, 0);
    repeat (3) @(negedge clk);
    #1 check("stall_rsp_count", rsp_cnt - rc0, 1);

    // Misaligned read: local SLVERR, no AR.
    ar0 = ar_cyc;
    issue(1'b0, 32'h3, 32'h0, 4'h0, 2'b10, 32'h0, 1, 0, 1'b0);
    repeat (2) @(negedge clk);
    #1 check("misaligned_no_ar", ar_cyc - ar0, 0);

    // Response back-pressure for 5 cycles.
    issue(1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 3, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    issue(1'b0, 32'h14, 32'h0, 4'h0, 2'b00, 32'h12345678, 3, 1, 1'b0);

    // Reset in the middle of a write.
    w_stall = 10;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    check("rst_test_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_test_awvalid", {31'b0, axi.awvalid}, 32'd1);
    rc0 = rsp_cnt;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    w_stall = 0;
    @(negedge clk);
    check("rst_mid_valids", {28'b0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready}, 32'd0);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    #1 check("rst_mid_no_rsp", rsp_cnt - rc0, 0);
    issue(1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0, 3, 0, 1'b0);
    issue(1'b0, 32'h18, 32'h0, 4'h0, 2'b00, 32'hCAFEF00D, 3, 0, 1'b0);

    // Slave error passes through.
    bresp_cfg = 2'b10;
    issue(1'b1, 32'h1C, 32'h00000055, 4'hF, 2'b10, 32'h0, 3, 0, 1'b0);
    @(posedge clk); #1 bresp_cfg = 2'b00;

    // Partial strobes merge into the existing word: 0x11223344 + AABBCCDD@0101.
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 2'b00, 32'h0, 3, 0, 1'b0);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2'b00, 32'h0, 3, 0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 2'b00, 32'h11BB33DD, 3, 0, 1'b0);

    // Misaligned write: SLVERR, no AW.
    aw0 = aw_cyc;
    issue(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0, 1, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("misaligned_no_aw", aw_cyc - aw0, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
